// File: rtl/rv_test_monitor.sv
// riscv-tests self-check monitor: shadows done/result/testnum regfile writes and issues a sticky verdict.
// Latency: a verdict flag rises SETTLE_CYCLES+1 cycles after the done write; timeout_o rises one cycle after watchdog expiry.
// Backpressure: none; passive snoop of the regfile write port, never stalls the core.
module rv_test_monitor #(
  parameter int                XLEN           = 32,
  parameter int                DONE_REG       = 26,
  parameter int                PASS_REG       = 27,
  parameter int                TNUM_REG       = 3,
  parameter logic [XLEN-1:0]   DONE_VAL       = {{(XLEN-1){1'b0}}, 1'b1},
  parameter logic [XLEN-1:0]   PASS_VAL       = {{(XLEN-1){1'b0}}, 1'b1},
  parameter int                SETTLE_CYCLES  = 10,
  parameter int                TIMEOUT_CYCLES = 0,
  parameter int                CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reg_we_i,
  input  logic [4:0]       reg_waddr_i,
  input  logic [XLEN-1:0]  reg_wdata_i,
  output logic             done_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic             timeout_o,
  output logic [XLEN-1:0]  testnum_o,
  output logic [CNT_W-1:0] cycles_o
);

  typedef enum logic [2:0] {
    S_RUN,
    S_SETTLE,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_t;

  localparam logic [4:0]  DONE_A      = 5'(DONE_REG);
  localparam logic [4:0]  PASS_A      = 5'(PASS_REG);
  localparam logic [4:0]  TNUM_A      = 5'(TNUM_REG);
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

  state_t           state_q;
  logic [XLEN-1:0]  pass_sh_q;
  logic [XLEN-1:0]  tnum_q;
  logic [31:0]      settle_cnt_q;
  logic [31:0]      run_cnt_q;
  logic [CNT_W-1:0] cycles_q;
  logic             done_q;
  logic             pass_q;
  logic             fail_q;
  logic             timeout_q;

  logic             active;
  logic             pass_wr;
  logic             tnum_wr;
  logic             done_hit;
  logic             pass_ok;
  logic             wd_expire;
  logic [XLEN-1:0]  pass_d;
  logic [XLEN-1:0]  tnum_d;
  logic [CNT_W-1:0] cycles_d;

  // Decode snooped writes and next values of shadows and the cycle counter.
  // The done register is acted on only as an event, so it needs no stored copy.
  always_comb begin
    active    = (state_q == S_RUN) || (state_q == S_SETTLE);
    pass_wr   = active && reg_we_i && (reg_waddr_i == PASS_A);
    tnum_wr   = active && reg_we_i && (reg_waddr_i == TNUM_A);
    done_hit  = (state_q == S_RUN) && reg_we_i && (reg_waddr_i == DONE_A) &&
                (reg_wdata_i == DONE_VAL);
    pass_d    = pass_wr ? reg_wdata_i : pass_sh_q;
    tnum_d    = tnum_wr ? reg_wdata_i : tnum_q;
    // The verdict sees a result write landing on the very edge that ends SETTLE.
    pass_ok   = (pass_d == PASS_VAL);
    wd_expire = (TIMEOUT_CYCLES != 0) && ((run_cnt_q + 32'd1) == TIMEOUT_LIM);
    cycles_d  = cycles_q;
    if (active && (cycles_q != {CNT_W{1'b1}})) begin
      cycles_d = cycles_q + CNT_W'(1);
    end
  end

  // Verdict FSM, shadow registers, counters and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RUN;
      pass_sh_q    <= '0;
      tnum_q       <= '0;
      settle_cnt_q <= '0;
      run_cnt_q    <= '0;
      cycles_q     <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      pass_sh_q <= pass_d;
      tnum_q    <= tnum_d;
      cycles_q  <= cycles_d;
      // Flags trail the state by one cycle so they are clean register outputs.
      pass_q    <= (state_q == S_PASS);
      fail_q    <= (state_q == S_FAIL);
      timeout_q <= (state_q == S_TIMEOUT);
      done_q    <= (state_q == S_PASS) || (state_q == S_FAIL) || (state_q == S_TIMEOUT);
      case (state_q)
        S_RUN: begin
          run_cnt_q <= run_cnt_q + 32'd1;
          // A done write beats a watchdog expiry in the same cycle.
          if (done_hit) begin
            state_q      <= S_SETTLE;
            settle_cnt_q <= '0;
          end else if (wd_expire) begin
            state_q <= S_TIMEOUT;
          end
        end
        S_SETTLE: begin
          // Repeated done writes are ignored; the window never restarts.
          if (settle_cnt_q == SETTLE_LAST) begin
            state_q <= pass_ok ? S_PASS : S_FAIL;
          end else begin
            settle_cnt_q <= settle_cnt_q + 32'd1;
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  assign done_o    = done_q;
  assign pass_o    = pass_q;
  assign fail_o    = fail_q;
  assign timeout_o = timeout_q;
  assign testnum_o = tnum_q;
  assign cycles_o  = cycles_q;

endmodule
